cosine_sim: RTL and testbench

Sequential fixed-point cosine-similarity engine. On a `start` pulse it latches two W-element signed vectors, accumulates their dot product and squared norms, then computes dot / sqrt(|A|²·|B|²) with an iterative square root and an iterative divider. The result is a signed Q16.15 value in [-1.0, +1.0]. It sits behind a register/accelerator front end that loads the vectors, pulses `start` and waits for `valid`.

---
 rtl/cosine_sim_pkg.sv | 22 ++
 rtl/cosine_isqrt.sv | 75 +++++++
 rtl/cosine_sim.sv | 196 +++++++++++++++++++
 tb/tb_cosine_sim.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cosine_sim_pkg.sv
// Shared constants, state encoding and width helper for the cosine-similarity engine.
package cosine_sim_pkg;

  localparam int DATA_W = 32;     // element width, signed Q16.15
  localparam int FRAC   = 15;     // fractional bits of the result
  localparam int ONE_Q  = 32768;  // +1.0 in Q16.15

  typedef enum logic [2:0] {
    IDLE,
    MAC,
    PROD,
    SQRT,
    DIV,
    DONE
  } cs_state_e;

  // Accumulator width: a full 64-bit product plus headroom for W terms.
  function automatic int acc_w(input int w);
    return 2 * DATA_W + $clog2(w);
  endfunction

endpackage

// File: rtl/cosine_isqrt.sv
// Iterative restoring integer square root: root = floor(sqrt(operand)).
// One result bit per cycle, N cycles. The first bit is resolved in the
// cycle that start is high, using operand directly, so done pulses in the
// cycle after the N-th step without an extra load cycle.
module cosine_isqrt #(
  parameter int N = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*N-1:0] operand,
  output logic [N-1:0]   root,
  output logic           done
);

  localparam int CNT_W = $clog2(N + 1);

  logic [2*N-1:0] op_reg;
  logic [N+1:0]   rem_reg;
  logic [N-1:0]   root_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic           busy_reg;
  logic           done_reg;

  logic [2*N-1:0] cur_op, op_step;
  logic [N+1:0]   cur_rem, rem_sh, trial, rem_step;
  logic [N-1:0]   cur_root, root_step;

  // One digit step: bring down two operand bits, try subtracting 4*root+1.
  always_comb begin
    cur_op   = start ? operand : op_reg;
    cur_rem  = start ? '0 : rem_reg;
    cur_root = start ? '0 : root_reg;
    rem_sh   = (cur_rem << 2) | {{N{1'b0}}, cur_op[2*N-1 -: 2]};
    trial    = {cur_root, 2'b01};
    if (rem_sh >= trial) begin
      rem_step  = rem_sh - trial;
      root_step = (cur_root << 1) | {{(N-1){1'b0}}, 1'b1};
    end else begin
      rem_step  = rem_sh;
      root_step = cur_root << 1;
    end
    op_step = cur_op << 2;
  end

  // Iteration control: count steps and pulse done after the last one.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_reg   <= '0;
      rem_reg  <= '0;
      root_reg <= '0;
      cnt_reg  <= '0;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (start || busy_reg) begin
        op_reg   <= op_step;
        rem_reg  <= rem_step;
        root_reg <= root_step;
        cnt_reg  <= start ? CNT_W'(1) : cnt_reg + CNT_W'(1);
        if (start ? (N == 1) : (cnt_reg == CNT_W'(N - 1))) begin
          busy_reg <= 1'b0;
          done_reg <= 1'b1;
        end else begin
          busy_reg <= 1'b1;
        end
      end
    end
  end

  assign root = root_reg;
  assign done = done_reg;

endmodule

// File: rtl/cosine_sim.sv
// Sequential cosine-similarity engine: dot / sqrt(|A|^2 * |B|^2) in Q16.15.
// MAC one element per cycle, one-cycle norm product, iterative square root
// (cosine_isqrt), then a 16-cycle restoring divide.
// Optional macro COSINE_SIM_ZERO_DET_EN adds the zero_vec output flag.
module cosine_sim
  import cosine_sim_pkg::*;
#(
  parameter int W = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [DATA_W-1:0]        vec_a [W-1:0],
  input  logic [DATA_W-1:0]        vec_b [W-1:0],
  output logic signed [DATA_W-1:0] similarity,
  output logic                     valid
`ifdef COSINE_SIM_ZERO_DET_EN
  ,
  output logic                     zero_vec
`endif
);

  localparam int ACC_W = acc_w(W);
  localparam int IDX_W = (W > 1) ? $clog2(W) : 1;
  localparam int QW    = FRAC + 1;        // quotient magnitude bits
  localparam int QC_W  = $clog2(QW);      // divide step counter

  cs_state_e state_reg;
  logic [IDX_W-1:0]        idx_reg;
  logic [DATA_W-1:0]       a_reg [W];
  logic [DATA_W-1:0]       b_reg [W];
  logic signed [ACC_W-1:0] dot_reg;
  logic [ACC_W-1:0]        na_reg, nb_reg;
  logic [ACC_W-1:0]        div_rem_reg;
  logic [QW-1:0]           div_num_reg;
  logic [QW-1:0]           q_reg;
  logic [QC_W-1:0]         div_cnt_reg;
  logic                    zero_reg;
  logic                    valid_reg;
  logic signed [DATA_W-1:0] sim_reg;

  logic                    launch;
  logic signed [DATA_W-1:0] cur_a, cur_b;
  logic signed [2*DATA_W-1:0] prod_ab, prod_aa, prod_bb;
  logic [2*ACC_W-1:0]      p_val;
  logic [ACC_W-1:0]        sqrt_root;
  logic                    sqrt_done;
  logic [ACC_W-1:0]        dot_mag;
  logic [ACC_W:0]          div_sh, d_ext;
  logic                    div_ge;
  logic [QW:0]             q_clamp;
  logic signed [DATA_W-1:0] q_signed, sim_val;

  assign launch = (state_reg == IDLE) && start;

  // Element products for the current MAC index, plus the norm product.
  always_comb begin
    cur_a   = a_reg[idx_reg];
    cur_b   = b_reg[idx_reg];
    prod_ab = (2*DATA_W)'(cur_a) * (2*DATA_W)'(cur_b);
    prod_aa = (2*DATA_W)'(cur_a) * (2*DATA_W)'(cur_a);
    prod_bb = (2*DATA_W)'(cur_b) * (2*DATA_W)'(cur_b);
    p_val   = (2*ACC_W)'(na_reg) * (2*ACC_W)'(nb_reg);
  end

  // Divider datapath and final signed, clamped result.
  always_comb begin
    dot_mag  = dot_reg[ACC_W-1] ? $unsigned(-dot_reg) : $unsigned(dot_reg);
    div_sh   = {div_rem_reg, div_num_reg[QW-1]};
    d_ext    = {1'b0, sqrt_root};
    div_ge   = (div_sh >= d_ext);
    q_clamp  = ({1'b0, q_reg} > (QW+1)'(ONE_Q)) ? (QW+1)'(ONE_Q) : {1'b0, q_reg};
    q_signed = {{(DATA_W-QW-1){1'b0}}, q_clamp};
    sim_val  = dot_reg[ACC_W-1] ? -q_signed : q_signed;
  end

  cosine_isqrt #(
    .N(ACC_W)
  ) u_isqrt (
    .clk     (clk),
    .rst     (rst),
    .start   (state_reg == PROD),
    .operand (p_val),
    .root    (sqrt_root),
    .done    (sqrt_done)
  );

  // Capture both vectors at launch so later input changes are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < W; i++) begin
        a_reg[i] <= '0;
        b_reg[i] <= '0;
      end
    end else if (launch) begin
      for (int i = 0; i < W; i++) begin
        a_reg[i] <= vec_a[i];
        b_reg[i] <= vec_b[i];
      end
    end
  end

  // Main sequencer: MAC, product, square root, divide, publish.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      idx_reg     <= '0;
      dot_reg     <= '0;
      na_reg      <= '0;
      nb_reg      <= '0;
      div_rem_reg <= '0;
      div_num_reg <= '0;
      q_reg       <= '0;
      div_cnt_reg <= '0;
      zero_reg    <= 1'b0;
      valid_reg   <= 1'b0;
      sim_reg     <= '0;
    end else begin
      valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= MAC;
            idx_reg   <= '0;
            dot_reg   <= '0;
            na_reg    <= '0;
            nb_reg    <= '0;
          end
        end
        MAC: begin
          dot_reg <= dot_reg + ACC_W'(prod_ab);
          na_reg  <= na_reg + ACC_W'($unsigned(prod_aa));
          nb_reg  <= nb_reg + ACC_W'($unsigned(prod_bb));
          if (idx_reg == IDX_W'(W - 1)) begin
            state_reg <= PROD;
          end else begin
            idx_reg <= idx_reg + IDX_W'(1);
          end
        end
        PROD: begin
          state_reg <= SQRT;
        end
        SQRT: begin
          if (sqrt_done) begin
            if (sqrt_root == '0) begin
              zero_reg  <= 1'b1;
              state_reg <= DONE;
            end else begin
              // |DOT| <= D, so the top part of |DOT|*2^15 is already below D.
              zero_reg    <= 1'b0;
              div_rem_reg <= dot_mag >> 1;
              div_num_reg <= {dot_mag[0], {FRAC{1'b0}}};
              q_reg       <= '0;
              div_cnt_reg <= '0;
              state_reg   <= DIV;
            end
          end
        end
        DIV: begin
          div_rem_reg <= div_ge ? ACC_W'(div_sh - d_ext) : ACC_W'(div_sh);
          q_reg       <= {q_reg[QW-2:0], div_ge};
          div_num_reg <= div_num_reg << 1;
          div_cnt_reg <= div_cnt_reg + QC_W'(1);
          if (div_cnt_reg == QC_W'(QW - 1)) begin
            state_reg <= DONE;
          end
        end
        DONE: begin
          sim_reg   <= zero_reg ? '0 : sim_val;
          valid_reg <= 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign similarity = sim_reg;
  assign valid      = valid_reg;

`ifdef COSINE_SIM_ZERO_DET_EN
  logic zero_out_reg;

  // Zero-vector flag, refreshed together with similarity.
  always_ff @(posedge clk) begin
    if (rst) begin
      zero_out_reg <= 1'b0;
    end else if (state_reg == DONE) begin
      zero_out_reg <= zero_reg;
    end
  end

  assign zero_vec = zero_out_reg;
`endif

endmodule

// File: tb/tb_cosine_sim.sv
// Self-checking bench for cosine_sim: directed table, randomized runs against
// a wide-arithmetic reference model, and abort / ignored-start sequences.
module tb_cosine_sim;

  localparam int W = 5;
  localparam int Q = 32768;
  localparam int LAT_FULL = 90;
  localparam int LAT_ZERO = 74;

  typedef logic [31:0] vec_t [5];
  typedef struct {
    vec_t a;
    vec_t b;
    int   exp_sim;
    int   exp_lat;
    bit   exp_zero;
  } dir_rec_t;

  logic               clk;
  logic               rst;
  logic               start;
  logic [31:0]        vec_a [W-1:0];
  logic [31:0]        vec_b [W-1:0];
  logic signed [31:0] similarity;
  logic               valid;
`ifdef COSINE_SIM_ZERO_DET_EN
  logic               zero_vec;
`endif

  int errors;
  int checks;
  dir_rec_t dir_tab [5];

  cosine_sim #(
    .W(W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .vec_a      (vec_a),
    .vec_b      (vec_b),
    .similarity (similarity),
    .valid      (valid)
`ifdef COSINE_SIM_ZERO_DET_EN
    ,
    .zero_vec   (zero_vec)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: exact wide integer arithmetic, bisection square root, native divide.
  function automatic longint model_sim(input vec_t a, input vec_t b, output bit zero);
    logic signed [127:0] dot;
    logic [127:0] na, nb;
    logic [255:0] p, lo, hi, mid, mag, quo;
    longint sa, sb;
    dot = '0;
    na  = '0;
    nb  = '0;
    for (int i = 0; i < 5; i++) begin
      sa  = longint'($signed(a[i]));
      sb  = longint'($signed(b[i]));
      dot = dot + 128'(sa * sb);
      na  = na + 128'(sa * sa);
      nb  = nb + 128'(sb * sb);
    end
    p  = 256'(na) * 256'(nb);
    lo = '0;
    hi = 256'(1) << 70;
    while (hi - lo > 1) begin
      mid = (lo + hi) >> 1;
      if (mid * mid <= p) lo = mid;
      else hi = mid;
    end
    zero = (lo == 0);
    if (zero) return 0;
    mag = (dot < 0) ? 256'(-dot) : 256'(dot);
    quo = (mag << 15) / lo;
    if (quo > 256'(Q)) quo = 256'(Q);
    return (dot < 0) ? -longint'(quo) : longint'(quo);
  endfunction

  task automatic drive_vec(input vec_t a, input vec_t b);
    for (int i = 0; i < W; i++) begin
      vec_a[i] = a[i];
      vec_b[i] = b[i];
    end
  endtask

  // Present vectors with a one-cycle start; returns just after the sampling edge.
  task automatic apply(input vec_t a, input vec_t b);
    @(negedge clk);
    drive_vec(a, b);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Cycles (edges) until valid is seen; -1 if the budget runs out.
  task automatic wait_valid(input int budget, output int lat);
    lat = -1;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_and_check(input string name, input vec_t a, input vec_t b,
                               input longint exp_sim, input int exp_lat,
                               input bit exp_zero, input bit scramble);
    int   lat;
    vec_t ra, rb;
    longint got;
    apply(a, b);
    if (scramble) begin
      for (int i = 0; i < 5; i++) begin
        ra[i] = $urandom;
        rb[i] = $urandom;
      end
      drive_vec(ra, rb);
    end
    wait_valid(200, lat);
    got = longint'(similarity);
    $display("op %s: sim=%0d exp=%0d lat=%0d zero=%0b", name, got, exp_sim, lat, exp_zero);
    check({name, " latency"}, lat, exp_lat);
    check({name, " similarity"}, got, exp_sim);
`ifdef COSINE_SIM_ZERO_DET_EN
    check({name, " zero_vec"}, longint'(zero_vec), longint'(exp_zero));
`endif
    @(negedge clk);
    check({name, " valid one cycle"}, longint'(valid), 0);
    check({name, " similarity held"}, longint'(similarity), exp_sim);
  endtask

  initial begin
    int     lat;
    vec_t   a, b;
    longint exp;
    bit     z;
    int     t;

    errors = 0;
    checks = 0;
    rst    = 1'b1;
    start  = 1'b0;
    for (int i = 0; i < W; i++) begin
      vec_a[i] = '0;
      vec_b[i] = '0;
    end

    // Directed vectors from the specification's test plan.
    for (int i = 0; i < 5; i++) begin
      dir_tab[0].a[i] = 32'(Q);
      dir_tab[0].b[i] = 32'(Q);
      dir_tab[1].a[i] = 32'((i + 1) * Q);
      dir_tab[1].b[i] = 32'(-(i + 1) * Q);
      dir_tab[2].a[i] = (i == 0) ? 32'(Q) : 32'd0;
      dir_tab[2].b[i] = (i == 1) ? 32'(Q) : 32'd0;
      dir_tab[3].a[i] = (i < 2) ? 32'(Q) : 32'd0;
      dir_tab[3].b[i] = (i == 0) ? 32'(Q) : 32'd0;
      dir_tab[4].a[i] = 32'd0;
      dir_tab[4].b[i] = 32'(Q);
    end
    dir_tab[0].exp_sim = 32768;  dir_tab[0].exp_lat = LAT_FULL; dir_tab[0].exp_zero = 1'b0;
    dir_tab[1].exp_sim = -32768; dir_tab[1].exp_lat = LAT_FULL; dir_tab[1].exp_zero = 1'b0;
    dir_tab[2].exp_sim = 0;      dir_tab[2].exp_lat = LAT_FULL; dir_tab[2].exp_zero = 1'b0;
    dir_tab[3].exp_sim = 23170;  dir_tab[3].exp_lat = LAT_FULL; dir_tab[3].exp_zero = 1'b0;
    dir_tab[4].exp_sim = 0;      dir_tab[4].exp_lat = LAT_ZERO; dir_tab[4].exp_zero = 1'b1;

    repeat (3) @(negedge clk);
    check("reset valid", longint'(valid), 0);
    check("reset similarity", longint'(similarity), 0);
`ifdef COSINE_SIM_ZERO_DET_EN
    check("reset zero_vec", longint'(zero_vec), 0);
`endif
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      run_and_check($sformatf("dir%0d", i), dir_tab[i].a, dir_tab[i].b,
                    dir_tab[i].exp_sim, dir_tab[i].exp_lat, dir_tab[i].exp_zero, 1'b0);
    end

    // Randomized runs against the reference model.
    for (int r = 0; r < 16; r++) begin
      for (int i = 0; i < 5; i++) begin
        case (r % 4)
          0: begin
            a[i] = $urandom;
            b[i] = $urandom;
          end
          1: begin
            a[i] = 32'($urandom_range(2000)) - 32'd1000;
            b[i] = 32'($urandom_range(2000)) - 32'd1000;
          end
          2: begin
            t    = int'($urandom_range(1 << 27));
            a[i] = 32'(t);
            b[i] = 32'(t) + 32'($urandom_range(100)) - 32'd50;
            if (r % 8 == 6) b[i] = -b[i];
          end
          default: begin
            a[i] = (r % 8 == 3) ? 32'd0 : $urandom;
            b[i] = (r % 8 == 3) ? $urandom : 32'd0;
          end
        endcase
      end
      exp = model_sim(a, b, z);
      run_and_check($sformatf("rnd%0d", r), a, b, exp, z ? LAT_ZERO : LAT_FULL, z, r[0]);
    end

    // Reset 20 cycles after start aborts the operation.
    run_and_check("pre_abort", dir_tab[0].a, dir_tab[0].b, 32768, LAT_FULL, 1'b0, 1'b0);
    apply(dir_tab[0].a, dir_tab[0].b);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort similarity cleared", longint'(similarity), 0);
    wait_valid(120, lat);
    $display("op abort: lat=%0d", lat);
    check("abort no valid", lat, -1);

    // A second start during MAC is ignored and not queued.
    apply(dir_tab[3].a, dir_tab[3].b);
    @(negedge clk);
    drive_vec(dir_tab[0].a, dir_tab[0].b);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid(150, lat);
    $display("op ignored_start: sim=%0d lat=%0d", similarity, lat + 2);
    check("ignored start latency", lat + 2, LAT_FULL);
    check("ignored start similarity", longint'(similarity), 23170);
    wait_valid(100, lat);
    check("no queued operation", lat, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
